// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: the NOP encoding,
// the branch/jump kind encodings that ID sends on jorB, and the FSM states.
package instr_fetch_pkg;

  localparam logic [15:0] NOP = 16'h0800;

  typedef enum logic [1:0] {
    JB_B    = 2'b00,
    JB_JR   = 2'b01,
    JB_BEQZ = 2'b10,
    JB_BNEZ = 2'b11
  } jorb_t;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory bus: the fetch stage drives address/request, the
// memory returns the word together with a one-cycle acknowledge.
interface instr_fetch_if;

  logic [15:0] imemAddr;
  logic        imemReq;
  logic [15:0] imemData;
  logic        imemAck;

  modport master (output imemAddr, imemReq, input imemData, imemAck);
  modport slave  (input imemAddr, imemReq, output imemData, imemAck);

endinterface

// File: rtl/instr_fetch_branch_resolve.sv
// Branch resolution for the instruction sitting in ID: decides whether the
// redirect is taken and where it goes. Purely combinational.
module branch_resolve
  import instr_fetch_pkg::*;
(
  input  logic        instr_valid,
  input  logic        if_jump,
  input  logic [1:0]  jor_b,
  input  logic [15:0] imm_num,
  input  logic [15:0] reg_data,
  input  logic [15:0] instr_pc,
  output logic        taken,
  output logic [15:0] target
);

  logic cond;

  // Condition per branch kind; if_jump is active-low as ID produces it.
  always_comb begin
    cond = 1'b0;
    case (jor_b)
      JB_B, JB_JR: cond = 1'b1;
      JB_BEQZ:     cond = (reg_data == 16'h0000);
      JB_BNEZ:     cond = (reg_data != 16'h0000);
      default:     cond = 1'b0;
    endcase
    taken  = instr_valid && !if_jump && cond;
    target = (jor_b == JB_JR) ? reg_data : instr_pc + imm_num;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage with one architectural delay slot. A redirect
// resolved while the delay-slot fetch is still outstanding is parked in
// pend_target and applied once that word arrives. A word acknowledged
// during a stall is parked in hold_reg so it is never refetched.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              ifJump,
  input  logic [1:0]        jorB,
  input  logic [15:0]       immNum,
  input  logic [15:0]       regData,
  instr_fetch_if.master     imem,
  output logic [15:0]       instr,
  output logic [15:0]       instrPC,
  output logic              instrValid
);

  state_t      state;
  logic [15:0] pc;
  logic [15:0] pend_target;
  logic        pending;
  logic [15:0] hold_reg;
  logic        req;

  logic        taken;
  logic [15:0] target;
  logic [15:0] pc_inc;
  logic [15:0] next_pc;

  branch_resolve u_branch_resolve (
    .instr_valid (instrValid),
    .if_jump     (ifJump),
    .jor_b       (jorB),
    .imm_num     (immNum),
    .reg_data    (regData),
    .instr_pc    (instrPC),
    .taken       (taken),
    .target      (target)
  );

  assign pc_inc  = pc + 16'd1;
  assign next_pc = pending ? pend_target : (taken ? target : pc_inc);

  assign imem.imemAddr = pc;
  assign imem.imemReq  = req;

  // Fetch FSM, PC, redirect bookkeeping and IF/ID latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_FETCH;
      req         <= 1'b1;
      pc          <= RESET_PC;
      pend_target <= 16'h0000;
      pending     <= 1'b0;
      hold_reg    <= 16'h0000;
      instr       <= NOP;
      instrPC     <= 16'h0000;
      instrValid  <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (!stall && imem.imemAck) begin
            instr      <= imem.imemData;
            instrPC    <= pc_inc;
            instrValid <= 1'b1;
            pc         <= next_pc;
            pending    <= 1'b0;
          end else if (!stall) begin
            instr      <= NOP;
            instrValid <= 1'b0;
            if (taken) begin
              pend_target <= target;
              pending     <= 1'b1;
            end
          end else if (imem.imemAck) begin
            hold_reg <= imem.imemData;
            state    <= S_HOLD;
            req      <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            instr      <= hold_reg;
            instrPC    <= pc_inc;
            instrValid <= 1'b1;
            pc         <= next_pc;
            pending    <= 1'b0;
            state      <= S_FETCH;
            req        <= 1'b1;
          end
        end
        default: begin
          state <= S_FETCH;
          req   <= 1'b1;
        end
      endcase
    end
  end

endmodule
